seq_det_sched: RTL and testbench
================================

# seq_det_sched

Round-robin scheduler that time-shares one overlapping serial pattern-detect engine among NCH independent bit streams. Per-channel bit history lives in a context table. The scheduler grants one requesting stream per cycle, restores that stream's context, evaluates the match, and writes the context back. It sits between the serial front-ends and the event/statistics logic, replacing one Moore detector per stream.

## Interface
- NCH, 4: number of streams, 2..16
- PAT_W, 4: pattern length in bits, 2..8
- PATTERN, 4'b1011: pattern to detect; MSB is the first bit received
- CNT_W, 16: width of the per-channel hit counters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NCH  per-channel bit-valid
- bit_in  in  NCH  per-channel serial data, qualified by req
- ch_clr  in  NCH  per-channel context clear
- gnt  out  NCH  one-hot grant; a bit is consumed when req[i] and gnt[i] are both high
- hit_valid  out  1  one-cycle hit pulse
- hit_ch  out  $clog2(NCH)  channel that produced the hit
- cnt_sel  in  $clog2(NCH)  counter read select
- cnt_out  out  CNT_W  hit count of channel cnt_sel

## Operation
- **Context per channel:**
  - hist[PAT_W-2:0]: last bits, newest in the LSB.
  - fill: saturating count, 0..PAT_W-1.
- **Arbitration:**
  - Eligible set is req & ~ch_clr.
  - Round-robin pointer ptr; search starts at ptr.
  - After a grant to channel k, ptr becomes (k+1) mod NCH.
  - ptr is unchanged when nothing is granted.
  - At most one gnt bit is high. gnt is 0 when the eligible set is empty.
- **Evaluate (granted channel k):**
  - w = {hist_k, bit_in[k]}.
  - Match when fill_k == PAT_W-1 and w == PATTERN.
  - Overlapping detection: history is kept after a match. Example: 1011011 yields 2 hits.
  - Update: hist_k = w[PAT_W-2:0]; fill_k increments, saturating at PAT_W-1.
- **Clear:**
  - ch_clr[i] sets hist_i and fill_i to 0 and zeroes counter i when compiled in.
  - A cleared channel is masked from arbitration that cycle, so its bit is not consumed and the source holds it.
- Contexts of ungranted channels are untouched.
- **Counters:** counter k increments on each hit, saturating at 2^CNT_W-1.

## Timing
- gnt is combinational from req, ch_clr and ptr in the same cycle.
- The context update lands on the clk edge that ends the handshake cycle.
- hit_valid and hit_ch are registered and valid in the cycle after the handshake (latency 1). hit_valid is low otherwise.
- hit_ch holds its last value when hit_valid is low.
- The counter updates on the same edge as hit_valid. cnt_out is a combinational read, so the new value is visible in the hit_valid cycle.
- Back-to-back grants to the same channel are allowed when it is the only requester: 1 bit per cycle.
- Reset values:
  - ptr = 0
  - all hist, fill and counters = 0
  - hit_valid = 0, hit_ch = 0
  - gnt follows the combinational logic, so it is 0 with req = 0.
- Reset mid-stream discards all partial matches. A hit pending in the output register is lost.
- Throughput: total one bit per cycle across all channels. With N active channels, each gets 1 bit per N cycles.

## Configuration
- **SEQ_DET_SCHED_HITCNT_EN defined:** per-channel CNT_W-bit saturating hit counters and the cnt_out mux are built.
- **Not defined:** no counters; cnt_out is tied to 0 and cnt_sel is ignored. Detection and arbitration are unchanged.

## Structure
- **Package seq_det_sched_pkg:**
  - default NCH, PAT_W, PATTERN, CNT_W
  - context struct typedef {hist, fill}
  - channel-index width function
- **Sub-module rr_arbiter:**
  - parameter N
  - ports: clk, rst, req, gnt
  - contains the pointer register
  - reusable elsewhere for shared resources
- The top level holds the context array, the match compare, the output register and the counters.

## Test plan
- **Single channel:** req[0] held high, bit_in[0] = 1,0,1,1,0,1,1 → hit_valid on cycles 5 and 8 (cycle after the 4th and 7th bit), hit_ch = 0, cnt_out(sel 0) = 2.
- **Interleaving:** ch0 and ch2 both stream 1011 with all req high.
  - gnt alternates ch0, ch2, ch0, ...
  - Contexts stay independent.
  - Exactly one hit per channel, hit_ch = 0 then 2, on consecutive hit cycles.
- **Fairness:** req = 4'b1111 for 8 cycles → gnt sequence 0,1,2,3,0,1,2,3. Drop req[1] → sequence becomes 0,2,3.
- **Clear collision:** ch1 has received 101; assert ch_clr[1] with req[1] and bit 1 → gnt[1] = 0 and no hit. The next 1011 on ch1 gives exactly one hit, and no hit occurs earlier.
- **Reset mid-pattern:** after 101 on ch0, pulse rst → ptr = 0 and counters = 0. The following bit 1 produces no hit.
- **Saturation (macro on, CNT_W = 4):** 17 hits on ch3 → cnt_out(sel 3) = 15. With the macro off, cnt_out = 0 throughout.

Source files
------------

// File: rtl/seq_det_sched_pkg.sv
// Shared defaults, per-channel context record and index-width helper for seq_det_sched.
package seq_det_sched_pkg;

    localparam int unsigned DEF_NCH     = 4;
    localparam int unsigned DEF_PAT_W   = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b1011;
    localparam int unsigned DEF_CNT_W   = 16;

    // Context record is sized for the largest supported pattern.
    localparam int unsigned MAX_PAT_W = 8;
    localparam int unsigned HIST_W    = MAX_PAT_W - 1;
    localparam int unsigned FILL_W    = 3;

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic [FILL_W-1:0] fill;
    } ctx_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at the registered pointer.
module rr_arbiter
    import seq_det_sched_pkg::*;
#(
    parameter int unsigned N = DEF_NCH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = idx_w(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found_c;

    // First requester at or after ptr wins; pointer moves just past the winner.
    always_comb begin
        gnt     = '0;
        ptr_d   = ptr_q;
        found_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_c && req[PW'((32'(ptr_q) + i) % N)]) begin
                found_c                           = 1'b1;
                gnt[PW'((32'(ptr_q) + i) % N)]    = 1'b1;
                ptr_d                             = PW'((32'(ptr_q) + i + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Time-shared overlapping pattern detector for NCH serial streams with per-channel context.
// Optional per-channel hit counters are built when SEQ_DET_SCHED_HITCNT_EN is defined.
module seq_det_sched
    import seq_det_sched_pkg::*;
#(
    parameter int unsigned      NCH     = DEF_NCH,
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int unsigned      CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           bit_in,
    input  logic [NCH-1:0]           ch_clr,
    output logic [NCH-1:0]           gnt,
    output logic                     hit_valid,
    output logic [$clog2(NCH)-1:0]   hit_ch,
    input  logic [$clog2(NCH)-1:0]   cnt_sel,
    output logic [CNT_W-1:0]         cnt_out
);

    localparam int unsigned       IW       = idx_w(NCH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [NCH-1:0]   elig_c;
    logic [IW-1:0]    gidx_c;
    logic [PAT_W-1:0] win_c;
    logic             match_c;

    ctx_t             ctx_q [NCH];
    ctx_t             ctx_d [NCH];
    logic             hit_valid_q;
    logic [IW-1:0]    hit_ch_q;

    // A channel being cleared must not consume its bit this cycle.
    assign elig_c = req & ~ch_clr;

    rr_arbiter #(.N(NCH)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (elig_c),
        .gnt (gnt)
    );

    always_comb begin
        gidx_c = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) gidx_c = IW'(i);
        end
    end

    assign win_c   = {ctx_q[gidx_c].hist[PAT_W-2:0], bit_in[gidx_c]};
    assign match_c = (|gnt) && (ctx_q[gidx_c].fill == FILL_MAX) && (win_c == PATTERN);

    // History keeps shifting after a hit so overlapping matches are found.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ctx_d[i] = ctx_q[i];
            if (ch_clr[i]) begin
                ctx_d[i] = '0;
            end else if (gnt[i]) begin
                ctx_d[i].hist = {ctx_q[i].hist[HIST_W-2:0], bit_in[i]};
                if (ctx_q[i].fill != FILL_MAX) begin
                    ctx_d[i].fill = ctx_q[i].fill + FILL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) ctx_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) ctx_q[i] <= ctx_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_valid_q <= 1'b0;
            hit_ch_q    <= '0;
        end else begin
            hit_valid_q <= match_c;
            if (match_c) hit_ch_q <= gidx_c;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_ch    = hit_ch_q;

`ifdef SEQ_DET_SCHED_HITCNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    // Saturating per-channel hit counters; a clear wins over a hit on the same channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ch_clr[i]) begin
                cnt_d[i] = '0;
            end else if (match_c && (gidx_c == IW'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign cnt_out = cnt_q[cnt_sel];
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: directed scenarios plus random traffic against a queue-based stream model.
module tb_seq_det_sched;

    localparam int NCH   = 4;
    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int IW    = 2;
    localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NCH-1:0]   req = '0;
    logic [NCH-1:0]   bit_in = '0;
    logic [NCH-1:0]   ch_clr = '0;
    logic [NCH-1:0]   gnt;
    logic             hit_valid;
    logic [IW-1:0]    hit_ch;
    logic [IW-1:0]    cnt_sel = '0;
    logic [CNT_W-1:0] cnt_out;

    int vectors     = 0;
    int miscompares = 0;

    // Model: bits accepted per channel since the last clear/reset (only the newest PAT_W kept).
    bit rx  [NCH][$];
    bit src [NCH][$];
    int cntm [NCH];
    int m_ptr    = 0;
    int m_hit_ch = 0;
    int m_k      = -1;
    int obs_g [$];
    int obs_h [$];
    int fair_exp [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};

    seq_det_sched #(
        .NCH     (NCH),
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bit_in    (bit_in),
        .ch_clr    (ch_clr),
        .gnt       (gnt),
        .hit_valid (hit_valid),
        .hit_ch    (hit_ch),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [NCH-1:0] v, input int i);
        logic [NCH-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic bit model_match(input int k);
        int n;
        int v;
        n = rx[k].size();
        v = 0;
        if (n < PAT_W) return 1'b0;
        for (int j = 0; j < PAT_W; j++) v = (v << 1) | int'(rx[k][n - PAT_W + j]);
        return v == int'(PATTERN);
    endfunction

    function automatic int exp_cnt(input int s);
`ifdef SEQ_DET_SCHED_HITCNT_EN
        return cntm[s];
`else
        return (s >= 0) ? 0 : 0;
`endif
    endfunction

    function automatic int pending();
        int t;
        t = 0;
        for (int i = 0; i < NCH; i++) t += src[i].size();
        return t;
    endfunction

    // One handshake cycle: check the grant, advance the model, check the registered outputs.
    task automatic cycle(input logic [NCH-1:0] r, input logic [NCH-1:0] b,
                         input logic [NCH-1:0] c, input int sel);
        logic [NCH-1:0] exp_gnt;
        bit             exp_hit;
        int             og;
        req = r; bit_in = b; ch_clr = c; cnt_sel = IW'(sel);
        #1;
        m_k = -1;
        for (int i = 0; i < NCH; i++) begin
            int j;
            j = (m_ptr + i) % NCH;
            if (m_k < 0 && bit_of(r, j) && !bit_of(c, j)) m_k = j;
        end
        exp_gnt = (m_k >= 0) ? (NCH'(1) << m_k) : '0;
        og = -1;
        for (int i = 0; i < NCH; i++) if (bit_of(gnt, i)) og = i;
        obs_g.push_back(og);
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        for (int i = 0; i < NCH; i++) begin
            if (bit_of(c, i)) begin
                rx[i].delete();
                cntm[i] = 0;
            end
        end
        exp_hit = 1'b0;
        if (m_k >= 0) begin
            rx[m_k].push_back(bit_of(b, m_k));
            if (rx[m_k].size() > PAT_W) void'(rx[m_k].pop_front());
            if (model_match(m_k)) begin
                exp_hit  = 1'b1;
                m_hit_ch = m_k;
                if (cntm[m_k] < CMAX) cntm[m_k]++;
            end
            m_ptr = (m_k + 1) % NCH;
        end
        @(posedge clk);
        #1;
        if (hit_valid === 1'b1) obs_h.push_back(int'(hit_ch));
        chk("hit_valid", 32'(hit_valid), 32'(exp_hit));
        chk("hit_ch", 32'(hit_ch), 32'(m_hit_ch));
        chk("cnt_out", 32'(cnt_out), 32'(exp_cnt(sel)));
    endtask

    task automatic push_bits(input int ch, input string s);
        for (int i = 0; i < s.len(); i++) src[ch].push_back(s[i] == 8'h31);
    endtask

    // Present every queued source bit until all are consumed; sources hold a bit until granted.
    task automatic run_src(input int sel);
        logic [NCH-1:0] r;
        logic [NCH-1:0] b;
        int             guard;
        guard = 0;
        while (pending() > 0 && guard < 500) begin
            r = '0;
            b = '0;
            for (int i = 0; i < NCH; i++) begin
                if (src[i].size() > 0) begin
                    r = r | (NCH'(1) << i);
                    if (src[i][0]) b = b | (NCH'(1) << i);
                end
            end
            cycle(r, b, '0, sel);
            if (m_k >= 0) void'(src[m_k].pop_front());
            guard++;
        end
        if (guard >= 500) begin
            miscompares++;
            $error("FAIL run_src: sources not drained after %0d cycles", guard);
        end
    endtask

    task automatic do_reset();
        req = '0; bit_in = '0; ch_clr = '0; cnt_sel = '0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NCH; i++) begin
            rx[i].delete();
            src[i].delete();
            cntm[i] = 0;
        end
        m_ptr = 0;
        m_hit_ch = 0;
        chk("rst_hit_valid", 32'(hit_valid), 32'd0);
        chk("rst_hit_ch", 32'(hit_ch), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_cnt", 32'(cnt_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        obs_g.delete();
        obs_h.delete();
    endtask

    initial begin
        string s;
        #2;
        do_reset();

        // Single channel 1011011: hits after the 4th and 7th bits
        s = "1011011";
        for (int i = 0; i < 7; i++) begin
            cycle(4'b0001, {3'b000, s[i] == 8'h31}, 4'b0000, 0);
            chk("single_hit_pos", 32'(hit_valid), 32'((i == 3) || (i == 6)));
        end
`ifdef SEQ_DET_SCHED_HITCNT_EN
        chk("single_cnt", 32'(cnt_out), 32'd2);
`else
        chk("single_cnt", 32'(cnt_out), 32'd0);
`endif
        chk("single_hits", 32'(obs_h.size()), 32'd2);

        // Interleaving ch0 and ch2
        do_reset();
        push_bits(0, "1011");
        push_bits(2, "1011");
        run_src(2);
        for (int i = 0; i < 4; i++) chk("interleave_gnt", 32'(obs_g[i]), 32'((i % 2 == 0) ? 0 : 2));
        chk("interleave_nhits", 32'(obs_h.size()), 32'd2);
        if (obs_h.size() == 2) begin
            chk("interleave_ch_a", 32'(obs_h[0]), 32'd0);
            chk("interleave_ch_b", 32'(obs_h[1]), 32'd2);
        end

        // Fairness: all four, then ch1 drops out
        do_reset();
        for (int i = 0; i < 8; i++) cycle(4'b1111, 4'($urandom), 4'b0000, $urandom_range(0, NCH - 1));
        for (int i = 0; i < 6; i++) cycle(4'b1101, 4'($urandom), 4'b0000, $urandom_range(0, NCH - 1));
        for (int i = 0; i < 14; i++) chk("fair_seq", 32'(obs_g[i]), 32'(fair_exp[i]));

        // Clear collision on ch1
        do_reset();
        push_bits(1, "101");
        run_src(1);
        cycle(4'b0010, 4'b0010, 4'b0010, 1);
        chk("clr_no_gnt", 32'(obs_g[$]), 32'(-1));
        push_bits(1, "1011");
        run_src(1);
        chk("clr_nhits", 32'(obs_h.size()), 32'd1);
        if (obs_h.size() == 1) chk("clr_hit_ch", 32'(obs_h[0]), 32'd1);

        // Reset mid-pattern: one hit, then 101 pending on ch0
        do_reset();
        push_bits(0, "10110101");
        run_src(0);
        chk("midrst_pre_hits", 32'(obs_h.size()), 32'd1);
        do_reset();
        cycle(4'b1111, 4'b0001, 4'b0000, 0);
        chk("midrst_ptr0", 32'(obs_g[$]), 32'd0);
        chk("midrst_nohit", 32'(obs_h.size()), 32'd0);

        // Saturation: 17 hits on ch3
        do_reset();
        push_bits(3, "1011");
        for (int i = 0; i < 16; i++) push_bits(3, "011");
        run_src(3);
        chk("sat_nhits", 32'(obs_h.size()), 32'd17);
        cnt_sel = 2'd3;
        #1;
`ifdef SEQ_DET_SCHED_HITCNT_EN
        chk("sat_cnt", 32'(cnt_out), 32'd15);
`else
        chk("sat_cnt", 32'(cnt_out), 32'd0);
`endif

        // Random traffic with occasional clears
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0] c;
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cycle(4'($urandom), 4'($urandom), c, $urandom_range(0, NCH - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
